dual_port_memory: RTL and testbench

- Unified instruction/data memory for the RV32I core.
- Instruction fetch port: read-only, synchronous.
- Data port: RISC-V sized loads/stores (byte, half, word) with byte-lane strobes, sign/zero extension and misalignment detection.
- Both ports have 1-cycle registered latency with request/valid handshakes. Backed by a single block RAM inferred as true dual-port.

---
 rtl/dual_port_memory.sv | 205 ++++++++++++++++++++
 tb/tb_dual_port_memory.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dual_port_memory.sv
// ----------------------------------------------------------------------------
// dual_port_memory
//   Unified instruction/data memory for an RV32I core, backed by one block RAM
//   used as a true dual-port array.
//
//   Port A: instruction fetch. It is read-only, with 1-cycle registered latency.
//   Port B: data load/store (LB/LH/LW/LBU/LHU, SB/SH/SW). It uses byte-lane
//           strobes, sign/zero extension, misalignment/range/funct3 fault
//           detection and 1-cycle registered latency.
//
//   Ports
//     clk, rst_n                    clock, asynchronous active-low reset
//     i_req, i_addr                 fetch request, byte address
//     i_inst, i_valid, i_err        fetched word, response strobe, fault
//     d_req, d_we, d_funct3         data request, store select, size/sign code
//     d_addr, d_wdata               byte address, right-aligned store data
//     d_rdata, d_valid, d_err       load result, response strobe, fault
// ----------------------------------------------------------------------------
module dual_port_memory #(
   parameter int WORD_LEN  = 32,   // lane/extension logic assumes 32
   parameter int ADDR_BITS = 12,
   parameter     INIT_FILE = ""
) (
   input  logic                clk,
   input  logic                rst_n,
   // instruction fetch port
   input  logic                i_req,
   input  logic [31:0]         i_addr,
   output logic [WORD_LEN-1:0] i_inst,
   output logic                i_valid,
   output logic                i_err,
   // data port
   input  logic                d_req,
   input  logic                d_we,
   input  logic [2:0]          d_funct3,
   input  logic [31:0]         d_addr,
   input  logic [WORD_LEN-1:0] d_wdata,
   output logic [WORD_LEN-1:0] d_rdata,
   output logic                d_valid,
   output logic                d_err
);

   localparam int DEPTH = 1 << ADDR_BITS;

   // funct3 encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   logic [WORD_LEN-1:0] mem [DEPTH];

   // -------------------------------------------------------------------------
   // Fetch decode
   // -------------------------------------------------------------------------
   logic [ADDR_BITS-1:0] i_idx;
   logic                 i_fault;

   assign i_idx   = i_addr[ADDR_BITS+1:2];
   assign i_fault = (|i_addr[1:0]) | (|i_addr[31:ADDR_BITS+2]);

   // -------------------------------------------------------------------------
   // Data decode: fault classification, strobes, lane replication
   // -------------------------------------------------------------------------
   logic [ADDR_BITS-1:0] d_idx;
   logic [1:0]           d_off;
   logic                 d_oor;
   logic                 d_bad_f3;
   logic                 d_misal;
   logic                 d_fault;
   logic [3:0]           d_strb;
   logic [WORD_LEN-1:0]  d_wrep;
   logic                 d_we_ok;
   logic                 d_re;

   assign d_idx = d_addr[ADDR_BITS+1:2];
   assign d_off = d_addr[1:0];
   assign d_oor = |d_addr[31:ADDR_BITS+2];

   always_comb begin
      d_bad_f3 = 1'b0;
      d_misal  = 1'b0;
      d_strb   = 4'b0000;
      d_wrep   = d_wdata;
      // 011/110/111 are never legal. Unsigned (1xx) codes are loads only.
      if (d_funct3 == 3'b011 || d_funct3[2:1] == 2'b11 || (d_we && d_funct3[2]))
         d_bad_f3 = 1'b1;
      case (d_funct3[1:0])
         2'b00: begin
            d_strb = 4'b0001 << d_off;
            d_wrep = {4{d_wdata[7:0]}};
         end
         2'b01: begin
            d_misal = d_off[0];
            d_strb  = d_off[1] ? 4'b1100 : 4'b0011;
            d_wrep  = {2{d_wdata[15:0]}};
         end
         2'b10: begin
            d_misal = |d_off;
            d_strb  = 4'b1111;
         end
         default: ;
      endcase
   end

   assign d_fault = d_bad_f3 | d_misal | d_oor;
   assign d_we_ok = d_req & d_we & ~d_fault;
   assign d_re    = d_req & ~d_we;

   // -------------------------------------------------------------------------
   // RAM array. Both ports sample the array with non-blocking semantics, so a
   // fetch that hits the word being stored in the same cycle sees the old
   // contents (read-first). A load in the cycle after a store sees the new data.
   // -------------------------------------------------------------------------
   logic [WORD_LEN-1:0] ram_i_q;
   logic [WORD_LEN-1:0] ram_d_q;

   always_ff @(posedge clk) begin
      if (i_req) ram_i_q <= mem[i_idx];
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (d_we_ok && d_strb[b]) mem[d_idx][b*8 +: 8] <= d_wrep[b*8 +: 8];
      end
      if (d_re) ram_d_q <= mem[d_idx];
   end

   // -------------------------------------------------------------------------
   // Response state
   // -------------------------------------------------------------------------
   logic       i_valid_q, i_valid_d;
   logic       i_err_q,   i_err_d;
   logic       i_zero_q,  i_zero_d;   // force i_inst to 0 (reset / faulted fetch)
   logic       d_valid_q, d_valid_d;
   logic       d_err_q,   d_err_d;
   logic       d_ld_q,    d_ld_d;     // good load: present extended data
   logic [2:0] f3_q,      f3_d;
   logic [1:0] off_q,     off_d;

   always_comb begin
      i_valid_d = i_req;
      i_err_d   = i_req & i_fault;
      // With no request, i_inst holds its value. Both the RAM register and this flag keep their state.
      i_zero_d  = i_req ? i_fault : i_zero_q;
      d_valid_d = d_req;
      d_err_d   = d_req & d_fault;
      d_ld_d    = d_re & ~d_fault;
      f3_d      = d_req ? d_funct3 : f3_q;
      off_d     = d_req ? d_off    : off_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_valid_q <= 1'b0;
         i_err_q   <= 1'b0;
         i_zero_q  <= 1'b1;
         d_valid_q <= 1'b0;
         d_err_q   <= 1'b0;
         d_ld_q    <= 1'b0;
         f3_q      <= 3'b000;
         off_q     <= 2'b00;
      end else begin
         i_valid_q <= i_valid_d;
         i_err_q   <= i_err_d;
         i_zero_q  <= i_zero_d;
         d_valid_q <= d_valid_d;
         d_err_q   <= d_err_d;
         d_ld_q    <= d_ld_d;
         f3_q      <= f3_d;
         off_q     <= off_d;
      end
   end

   // -------------------------------------------------------------------------
   // Load alignment and extension, from the registered offset/funct3
   // -------------------------------------------------------------------------
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;
   logic [WORD_LEN-1:0] ld_ext;

   assign ld_byte = ram_d_q[{off_q, 3'b000} +: 8];
   assign ld_half = off_q[1] ? ram_d_q[31:16] : ram_d_q[15:0];

   always_comb begin
      ld_ext = '0;
      case (f3_q)
         F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   ld_ext = {24'h0, ld_byte};
         F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ld_ext = {16'h0, ld_half};
         F3_W:    ld_ext = ram_d_q;
         default: ld_ext = '0;
      endcase
   end

   assign i_inst  = i_zero_q ? '0 : ram_i_q;
   assign i_valid = i_valid_q;
   assign i_err   = i_err_q;
   assign d_rdata = d_ld_q ? ld_ext : '0;
   assign d_valid = d_valid_q;
   assign d_err   = d_err_q;

endmodule

// File: tb/tb_dual_port_memory.sv
module tb_dual_port_memory;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_inst;
   logic        i_valid, i_err;
   logic        d_req, d_we;
   logic [2:0]  d_funct3;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        d_valid, d_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dual_port_memory #(.WORD_LEN(32), .ADDR_BITS(12), .INIT_FILE("")) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_inst(i_inst), .i_valid(i_valid), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err)
   );

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vq[$];

   task automatic addv(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rd = exp_rd; v.exp_err = exp_err;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_funct3 = '0; d_addr = '0; d_wdata = '0;

      // Stores: SB 000, SH 001, SW 010. Loads add 100 LBU and 101 LHU.
      addv(1, 3'b010, 32'h0,    32'h0000_0013, 32'h0, 0);
      addv(1, 3'b010, 32'h4,    32'hDEAD_BEEF, 32'h0, 0);
      addv(1, 3'b010, 32'h40,   32'h0000_0000, 32'h0, 0);
      addv(1, 3'b010, 32'h80,   32'h8BCD_1234, 32'h0, 0);
      addv(0, 3'b000, 32'h83,   32'h0, 32'hFFFF_FF8B, 0);  // store->load back-to-back
      addv(0, 3'b100, 32'h83,   32'h0, 32'h0000_008B, 0);
      addv(0, 3'b001, 32'h82,   32'h0, 32'hFFFF_8BCD, 0);
      addv(0, 3'b101, 32'h80,   32'h0, 32'h0000_1234, 0);
      addv(1, 3'b010, 32'h80,   32'h1122_3344, 32'h0, 0);
      addv(1, 3'b000, 32'h81,   32'h0000_00AA, 32'h0, 0);
      addv(0, 3'b010, 32'h80,   32'h0, 32'h1122_AA44, 0);
      addv(1, 3'b001, 32'h82,   32'h0000_5566, 32'h0, 0);
      addv(0, 3'b010, 32'h80,   32'h0, 32'h5566_AA44, 0);
      addv(0, 3'b010, 32'h82,   32'h0, 32'h0, 1);          // misaligned LW
      addv(1, 3'b001, 32'h81,   32'h0000_FFFF, 32'h0, 1);  // misaligned SH
      addv(0, 3'b010, 32'h1_0000, 32'h0, 32'h0, 1);        // out of range
      addv(0, 3'b011, 32'h80,   32'h0, 32'h0, 1);          // illegal funct3
      addv(1, 3'b100, 32'h80,   32'h0000_00FF, 32'h0, 1);  // unsigned code on store
      addv(1, 3'b010, 32'h4000, 32'h1234_5678, 32'h0, 1);  // would alias word 0
      addv(1, 3'b010, 32'h3FFC, 32'hA5A5_A5A5, 32'h0, 0);  // last word
      addv(0, 3'b010, 32'h3FFC, 32'h0, 32'hA5A5_A5A5, 0);
      addv(0, 3'b010, 32'h80,   32'h0, 32'h5566_AA44, 0);  // faults wrote nothing
      addv(0, 3'b010, 32'h0,    32'h0, 32'h0000_0013, 0);
      addv(0, 3'b000, 32'h80,   32'h0, 32'h0000_0044, 0);
      addv(0, 3'b101, 32'h82,   32'h0, 32'h0000_5566, 0);
      addv(0, 3'b000, 32'h82,   32'h0, 32'h0000_0066, 0);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_i_valid", {31'h0, i_valid}, 32'h0);
      chk("rst_i_err",   {31'h0, i_err},   32'h0);
      chk("rst_i_inst",  i_inst,           32'h0);
      chk("rst_d_valid", {31'h0, d_valid}, 32'h0);
      chk("rst_d_err",   {31'h0, d_err},   32'h0);
      chk("rst_d_rdata", d_rdata,          32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // table: one data request per cycle, back-to-back
      foreach (vq[k]) begin
         d_req = 1'b1; d_we = vq[k].we; d_funct3 = vq[k].f3;
         d_addr = vq[k].addr; d_wdata = vq[k].wdata;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_valid", k), {31'h0, d_valid}, 32'h1);
         chk($sformatf("vec%0d_err", k),   {31'h0, d_err},   {31'h0, vq[k].exp_err});
         chk($sformatf("vec%0d_rdata", k), d_rdata,          vq[k].exp_rd);
      end
      d_req = 1'b0; d_we = 1'b0;

      // fetch 0x0 then 0x4 back-to-back, then idle
      i_req = 1'b1; i_addr = 32'h0;
      @(posedge clk); #1;
      chk("f0_valid", {31'h0, i_valid}, 32'h1);
      chk("f0_inst",  i_inst,           32'h0000_0013);
      chk("f0_err",   {31'h0, i_err},   32'h0);
      chk("d_idle_valid", {31'h0, d_valid}, 32'h0);
      i_addr = 32'h4;
      @(posedge clk); #1;
      chk("f1_valid", {31'h0, i_valid}, 32'h1);
      chk("f1_inst",  i_inst,           32'hDEAD_BEEF);
      chk("f1_err",   {31'h0, i_err},   32'h0);
      i_req = 1'b0;
      @(posedge clk); #1;
      chk("fidle_valid", {31'h0, i_valid}, 32'h0);
      chk("fidle_hold",  i_inst,           32'hDEAD_BEEF);

      // fetch faults
      i_req = 1'b1; i_addr = 32'h2;
      @(posedge clk); #1;
      chk("fmis_valid", {31'h0, i_valid}, 32'h1);
      chk("fmis_err",   {31'h0, i_err},   32'h1);
      chk("fmis_inst",  i_inst,           32'h0);
      i_addr = 32'h4000;
      @(posedge clk); #1;
      chk("foor_err",  {31'h0, i_err}, 32'h1);
      chk("foor_inst", i_inst,         32'h0);

      // fetch and store to the same word in one cycle: read-first
      i_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h40; d_wdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      chk("conf_inst",    i_inst,           32'h0);
      chk("conf_ierr",    {31'h0, i_err},   32'h0);
      chk("conf_d_valid", {31'h0, d_valid}, 32'h1);
      chk("conf_d_rdata", d_rdata,          32'h0);
      d_req = 1'b0; d_we = 1'b0;
      @(posedge clk); #1;
      chk("conf_next_inst", i_inst, 32'hCAFE_F00D);

      // async reset mid-stream with both requests high
      d_req = 1'b1; d_funct3 = 3'b010; d_addr = 32'h40;
      @(posedge clk); #1;
      chk("pre_rst_inst",  i_inst,  32'hCAFE_F00D);
      chk("pre_rst_rdata", d_rdata, 32'hCAFE_F00D);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_i_valid", {31'h0, i_valid}, 32'h0);
      chk("arst_i_inst",  i_inst,           32'h0);
      chk("arst_d_valid", {31'h0, d_valid}, 32'h0);
      chk("arst_d_rdata", d_rdata,          32'h0);
      @(posedge clk); #1;
      chk("rst_hold_i_valid", {31'h0, i_valid}, 32'h0);
      chk("rst_hold_d_valid", {31'h0, d_valid}, 32'h0);
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_i_valid", {31'h0, i_valid}, 32'h0);
      chk("post_rst_d_valid", {31'h0, d_valid}, 32'h0);
      chk("post_rst_i_inst",  i_inst,           32'h0);
      i_req = 1'b1; i_addr = 32'h40;
      @(posedge clk); #1;
      chk("post_rst_fetch_valid", {31'h0, i_valid}, 32'h1);
      chk("post_rst_fetch_inst",  i_inst,           32'hCAFE_F00D);
      i_req = 1'b0;
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
